// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM encoding, PC width and reset vector default.
package fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FLUSH = 3'd4
  } fetch_state_e;

  function automatic logic [PC_W-1:0] align_pc(
    input logic [PC_W-1:0] pc
  );
    return {pc[PC_W-1:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(
    input logic [PC_W-1:0] pc
  );
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_next_unit.sv
// Program counter register with +4 adder and redirect mux.
// Redirect targets are word-aligned before being loaded.
module pc_next_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] redirect_pc_i,
  input  logic            advance_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic            misalign_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] sum;

  assign sum = pc_q + PC_W'(4);

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = align_pc(redirect_pc_i);
    end else if (advance_i) begin
      pc_d = sum;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o       = pc_q;
  assign pc_plus4_o = sum;
  assign misalign_o = redirect_i
                   && is_misaligned(redirect_pc_i);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: single-outstanding imem request FSM,
// instruction hold buffer and consumed-instruction counter.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            imem_req_valid,
  output logic [PC_W-1:0] imem_req_addr,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus4,
  output logic            instr_valid,
  output logic [31:0]     instr_out,
  output logic            misalign_err,
  output logic [31:0]     fetch_count
);

  fetch_state_e state_q;
  fetch_state_e state_d;

  logic [31:0] instr_q;
  logic [31:0] instr_d;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        misalign_q;
  logic        misalign_d;

  logic redir_acc;
  logic consume;
  logic capture;
  logic misalign_now;

  // IDLE is the only state that ignores redirects
  assign redir_acc = redirect_valid
                  && (state_q != ST_IDLE);
  assign consume   = (state_q == ST_HOLD)
                  && !stall && !redirect_valid;
  assign capture   = (state_q == ST_WAIT)
                  && imem_rsp_valid && !redirect_valid;

  pc_next_unit #(
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk          (clk),
    .reset        (reset),
    .redirect_i   (redir_acc),
    .redirect_pc_i(redirect_pc),
    .advance_i    (consume),
    .pc_o         (pc_out),
    .pc_plus4_o   (pc_plus4),
    .misalign_o   (misalign_now)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_req_ready) begin
          state_d = redirect_valid ? ST_FLUSH : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = redirect_valid ? ST_REQ : ST_HOLD;
        end else if (redirect_valid) begin
          state_d = ST_FLUSH;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || !stall) begin
          state_d = ST_REQ;
        end
      end
      // the in-flight response is dropped here
      ST_FLUSH: begin
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = 1'b0;
    instr_valid    = 1'b0;
    unique case (state_q)
      ST_REQ:  imem_req_valid = 1'b1;
      ST_HOLD: instr_valid    = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    instr_d    = capture ? imem_rsp_data : instr_q;
    count_d    = consume ? count_q + 32'd1 : count_q;
    misalign_d = misalign_now;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req_addr = pc_out;
  assign instr_out     = instr_q;
  assign fetch_count   = count_q;
  assign misalign_err  = misalign_q;

endmodule
